hex_display_ctrl: RTL and testbench
===================================

# hex_display_ctrl

Parametrised seven-segment controller driving a bank of hex digits from a packed nibble word. It replaces the fixed four-digit combinational lookup with a registered block that latches on a load strobe. It adds per-digit blanking, PWM brightness and a multiplexed scan output for boards with common-anode or common-cathode scanned displays. It sits in the board toplevel between the VirtualToplevel debug/hex bus and the HEXn pins or the GPIO display header.

## Interface
- DIGITS, 8, number of digits (1..16)
- ACTIVE_LOW, 1, 1 = segment and digit outputs are active-low (DE2 HEXn); 0 = active-high
- SCAN_DIV, 1024, clk cycles per digit slot in scan mode (>= 2)
- PWM_BITS, 4, brightness resolution

Ports:
- clk  in  1  system clock
- reset_in  in  1  synchronous, active-high reset
- value  in  4*DIGITS  packed nibbles; digit 0 = value[3:0]
- load  in  1  single-cycle strobe; captures value and blank_mask
- blank_mask  in  DIGITS  1 = force digit dark
- brightness  in  PWM_BITS  duty control; 0 = off, all-ones = 100 %
- segs  out  7*DIGITS  static outputs; digit n at segs[7n+6:7n], bit0 = a … bit6 = g
- scan_seg  out  7  multiplexed segment bus
- scan_dig  out  DIGITS  one-hot digit enable for scan_seg
- shown  out  1  high once a value has been loaded since reset

## Operation
- Font, active-high (a = bit0): 0 3F, 1 06, 2 5B, 3 4F, 4 66, 5 6D, 6 7D, 7 07, 8 7F, 9 6F, A 77, b 7C, C 39, d 5E, E 79, F 71. Dark = 00. With ACTIVE_LOW = 1, all of segs, scan_seg and scan_dig are inverted at the output register.
- Capture: on load, the value and mask registers update, and shown sets. Before the first load, every digit is dark.
- Digit n is lit iff all of the following hold:
  - shown = 1
  - mask bit n = 0
  - not leading-zero blanked (see Configuration)
  - the PWM gate is on
- PWM: a free-running PWM_BITS counter. The gate is on when count < bright_reg, or when bright_reg is all-ones.
  - bright_reg samples brightness only when the counter wraps to 0, so there are no partial-period glitches.
- Scan FSM, states SLOT and GAP:
  - The prescaler counts 0..SCAN_DIV-1.
  - GAP: cycle 0 of each slot. scan_dig is all inactive (anti-ghosting) and scan_seg shows the new digit's pattern.
  - SLOT: remaining SCAN_DIV-1 cycles. scan_dig is one-hot at the index.
  - At prescaler terminal count, the index increments and wraps DIGITS-1 → 0.
  - The PWM gate also applies to scan_dig.
- Static segs and the scan outputs are always both driven. The toplevel chooses which to wire.

## Timing
- All outputs are registered.
- load at cycle t → segs and scan_seg reflect the new value at t+1 (scan_seg only if the current index is affected).
- Reset (1 cycle minimum; any cycle, including mid-slot) gives:
  - shown = 0
  - value and mask registers = 0
  - bright_reg = 0, PWM counter = 0
  - prescaler = 0, index = 0, state = GAP
  - segs and scan_seg all dark; scan_dig all inactive
- load asserted during reset_in is ignored.
- Back-to-back loads: the last one wins; each is visible one cycle later.
- Brightness change: takes effect at the next PWM wrap, at most 2^PWM_BITS cycles later.
- DIGITS = 1: the index stays 0, and the GAP cycle still occurs every SCAN_DIV cycles.

## Configuration
- HEXDISP_LZB_EN defined: leading-zero blanking.
  - Digit n (n > 0) is dark when it and every higher digit hold nibble 0.
  - Digit 0 is never LZB-blanked.
  - Blanking is computed from the captured value and registered with it, so it has the same 1-cycle latency.
- Not defined: zeros are always displayed; the blanking logic is absent.

## Test plan
- Reset, then no load, for 100 cycles with brightness all-ones → segs all 1 (ACTIVE_LOW), scan_dig all 1, shown = 0.
- load value = 0x0123ABCF, brightness all-ones, DIGITS = 8, LZB off → next cycle digit0..7 = F 71, C 39, B 7C, A 77, 3 4F, 2 5B, 1 06, 0 3F (inverted at pins); shown = 1.
- Same value with HEXDISP_LZB_EN → digit 7 dark, digits 0..6 unchanged. value = 0 → only digit 0 lit, showing 3F.
- SCAN_DIV = 4, DIGITS = 3, sequence observed for 12 cycles (per slot: 1 GAP cycle, then 3 SLOT cycles) → scan_dig one-hot for indices 0, 1, 2, back to 0, inactive on each GAP cycle; scan_seg matches each digit.
- brightness = 4 (PWM_BITS = 4) → digit lit exactly 4 of every 16 cycles. Change to 12 mid-period → the new duty starts at the counter wrap.
- Assert reset_in mid-slot with load high in the same cycle → all outputs dark, shown = 0, index 0 on release.

Source files
------------

// File: rtl/hex_display_ctrl.sv
// -----------------------------------------------------------------------------
// hex_display_ctrl
//
// Registered seven-segment controller for a bank of DIGITS hex digits.
// A load strobe captures a packed nibble word and a per-digit blanking mask.
// Every digit is then driven two ways at once:
//   - static: one 7-bit pattern per digit on segs
//   - scanned: one shared 7-bit bus (scan_seg) plus a one-hot digit enable
//     (scan_dig) that steps through the digits every SCAN_DIV cycles
// The board toplevel decides which of the two to wire to pins. A free-running
// PWM counter dims all lit digits according to brightness.
//
// Optional feature macro:
//   HEXDISP_LZB_EN  leading-zero blanking. Digit n (n > 0) goes dark when it
//                   and every higher digit hold nibble 0.
//
// Parameters:
//   DIGITS      number of digits (1..16)
//   ACTIVE_LOW  1 = segs, scan_seg and scan_dig are active-low at the pins
//   SCAN_DIV    clk cycles per digit slot in scan mode (>= 2)
//   PWM_BITS    brightness resolution
//
// Ports:
//   clk         system clock
//   reset_in    synchronous active-high reset
//   value       packed nibbles, digit 0 = value[3:0]
//   load        single-cycle strobe; captures value and blank_mask
//   blank_mask  1 = force digit dark
//   brightness  duty control, 0 = off, all-ones = 100 %
//   segs        static outputs, digit n at segs[7n+6:7n], bit0 = a .. bit6 = g
//   scan_seg    multiplexed segment bus
//   scan_dig    one-hot digit enable for scan_seg
//   shown       high once a value has been loaded since reset
// -----------------------------------------------------------------------------
module hex_display_ctrl #(
   parameter int DIGITS     = 8,
   parameter bit ACTIVE_LOW = 1'b1,
   parameter int SCAN_DIV   = 1024,
   parameter int PWM_BITS   = 4
) (
   input  logic                  clk,
   input  logic                  reset_in,
   input  logic [4*DIGITS-1:0]   value,
   input  logic                  load,
   input  logic [DIGITS-1:0]     blank_mask,
   input  logic [PWM_BITS-1:0]   brightness,
   output logic [7*DIGITS-1:0]   segs,
   output logic [6:0]            scan_seg,
   output logic [DIGITS-1:0]     scan_dig,
   output logic                  shown
);

   localparam int PRESC_W = $clog2(SCAN_DIV);
   localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   // Output polarity masks; XOR with these converts active-high internal
   // patterns to pin polarity. Reset values are the "dark" pin levels.
   localparam logic [7*DIGITS-1:0] SEGS_POL = {(7*DIGITS){ACTIVE_LOW}};
   localparam logic [6:0]          SSEG_POL = {7{ACTIVE_LOW}};
   localparam logic [DIGITS-1:0]   SDIG_POL = {DIGITS{ACTIVE_LOW}};

   // GAP is cycle 0 of every slot: scan_dig is held inactive while scan_seg
   // already settles to the new digit, so the previous digit never ghosts.
   typedef enum logic {
      ST_GAP  = 1'b0,
      ST_SLOT = 1'b1
   } scan_state_t;

   // Active-high font, a = bit0.
   function automatic logic [6:0] font(input logic [3:0] nib);
      logic [6:0] pat;
      case (nib)
         4'h0: pat = 7'h3F;
         4'h1: pat = 7'h06;
         4'h2: pat = 7'h5B;
         4'h3: pat = 7'h4F;
         4'h4: pat = 7'h66;
         4'h5: pat = 7'h6D;
         4'h6: pat = 7'h7D;
         4'h7: pat = 7'h07;
         4'h8: pat = 7'h7F;
         4'h9: pat = 7'h6F;
         4'hA: pat = 7'h77;
         4'hB: pat = 7'h7C;
         4'hC: pat = 7'h39;
         4'hD: pat = 7'h5E;
         4'hE: pat = 7'h79;
         default: pat = 7'h71;
      endcase
      return pat;
   endfunction

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   logic [4*DIGITS-1:0]  value_reg;
   logic [DIGITS-1:0]    mask_reg;
   logic [PWM_BITS-1:0]  bright_reg;
   logic [PWM_BITS-1:0]  pwm_cnt;
   logic [PRESC_W-1:0]   presc;
   logic [IDX_W-1:0]     idx;
   scan_state_t          state;

   // ---------------------------------------------------------------------------
   // Next-state values. The output registers are loaded from these, so every
   // registered output always matches the state registers of the same cycle;
   // this is what gives a load at cycle t its effect at t+1.
   // ---------------------------------------------------------------------------
   logic [4*DIGITS-1:0]  value_nxt;
   logic [DIGITS-1:0]    mask_nxt;
   logic                 shown_nxt;
   logic [PWM_BITS-1:0]  pwm_nxt;
   logic [PWM_BITS-1:0]  bright_nxt;
   logic                 gate_nxt;
   logic                 presc_tc;
   logic [PRESC_W-1:0]   presc_nxt;
   logic [IDX_W-1:0]     idx_nxt;
   scan_state_t          state_nxt;
   logic [DIGITS-1:0]    lzb_nxt;
   logic [DIGITS-1:0]    lit_nxt;
   logic [7*DIGITS-1:0]  segs_nxt;
   logic [6:0]           scan_seg_nxt;
   logic [DIGITS-1:0]    scan_dig_nxt;

   always_comb begin
      value_nxt = load ? value : value_reg;
      mask_nxt  = load ? blank_mask : mask_reg;
      shown_nxt = shown | load;

      // Brightness is only resampled as the counter wraps to 0, so a change
      // never produces a truncated or doubled on-time within one period.
      pwm_nxt    = pwm_cnt + PWM_BITS'(1);
      bright_nxt = (pwm_nxt == '0) ? brightness : bright_reg;
      gate_nxt   = (pwm_nxt < bright_nxt) || (&bright_nxt);

      presc_tc  = (presc == PRESC_W'(SCAN_DIV - 1));
      presc_nxt = presc_tc ? '0 : presc + PRESC_W'(1);
      if (presc_tc)
         idx_nxt = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
      else
         idx_nxt = idx;

      case (state)
         ST_GAP:  state_nxt = ST_SLOT;
         default: state_nxt = presc_tc ? ST_GAP : ST_SLOT;
      endcase
   end

   // Leading-zero blanking runs from the top digit down; the run of zeros is
   // broken by the first non-zero nibble. Masked digits still count as their
   // nibble value, so masking does not change which zeros are "leading".
`ifdef HEXDISP_LZB_EN
   logic zero_run;
   always_comb begin
      zero_run = 1'b1;
      lzb_nxt  = '0;
      for (int n = DIGITS - 1; n >= 0; n--) begin
         zero_run   = zero_run & (value_nxt[4*n +: 4] == 4'h0);
         lzb_nxt[n] = (n != 0) && zero_run;
      end
   end
`else
   assign lzb_nxt = '0;
`endif

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // through the loop can leave one unassigned and infer a latch.
      lit_nxt      = '0;
      segs_nxt     = '0;
      scan_seg_nxt = '0;
      scan_dig_nxt = '0;
      for (int n = 0; n < DIGITS; n++) begin
         lit_nxt[n] = shown_nxt & ~mask_nxt[n] & ~lzb_nxt[n] & gate_nxt;
         if (lit_nxt[n])
            segs_nxt[7*n +: 7] = font(value_nxt[4*n +: 4]);
         // Compare against the loop index rather than indexing by idx_nxt,
         // which stays in range for any DIGITS including non-powers of two.
         if (IDX_W'(n) == idx_nxt) begin
            scan_seg_nxt    = segs_nxt[7*n +: 7];
            scan_dig_nxt[n] = (state_nxt == ST_SLOT) && lit_nxt[n];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Single clocked process: state, FSM and registered outputs.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      if (reset_in) begin
         value_reg  <= '0;
         mask_reg   <= '0;
         shown      <= 1'b0;
         bright_reg <= '0;
         pwm_cnt    <= '0;
         presc      <= '0;
         idx        <= '0;
         state      <= ST_GAP;
         segs       <= SEGS_POL;
         scan_seg   <= SSEG_POL;
         scan_dig   <= SDIG_POL;
      end else begin
         value_reg  <= value_nxt;
         mask_reg   <= mask_nxt;
         shown      <= shown_nxt;
         bright_reg <= bright_nxt;
         pwm_cnt    <= pwm_nxt;
         presc      <= presc_nxt;
         idx        <= idx_nxt;
         state      <= state_nxt;
         segs       <= segs_nxt ^ SEGS_POL;
         scan_seg   <= scan_seg_nxt ^ SSEG_POL;
         scan_dig   <= scan_dig_nxt ^ SDIG_POL;
      end
   end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hex_display_ctrl
//
// Three instances of hex_display_ctrl share clock, reset, load and brightness:
//   u_dut8  DIGITS=8, active-low, SCAN_DIV=4  (static font / mask / PWM)
//   u_dut3  DIGITS=3, active-high, SCAN_DIV=4 (scan sequence)
//   u_dut1  DIGITS=1, active-low, SCAN_DIV=2  (single-digit scan corner)
// Expected values are hand-computed constants. Leading-zero expectations
// follow HEXDISP_LZB_EN so the bench matches whichever build it is given.
// -----------------------------------------------------------------------------
module tb_hex_display_ctrl;

   logic        clk = 1'b0;
   logic        reset_in;
   logic        load;
   logic [3:0]  brightness;

   logic [31:0] value8;
   logic [7:0]  mask8;
   logic [55:0] segs8;
   logic [6:0]  scan_seg8;
   logic [7:0]  scan_dig8;
   logic        shown8;

   logic [11:0] value3;
   logic [2:0]  mask3;
   logic [20:0] segs3;
   logic [6:0]  scan_seg3;
   logic [2:0]  scan_dig3;
   logic        shown3;

   logic [3:0]  value1;
   logic [0:0]  mask1;
   logic [6:0]  segs1;
   logic [6:0]  scan_seg1;
   logic [0:0]  scan_dig1;
   logic        shown1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   hex_display_ctrl #(.DIGITS(8), .ACTIVE_LOW(1'b1), .SCAN_DIV(4), .PWM_BITS(4)) u_dut8 (
      .clk(clk), .reset_in(reset_in), .value(value8), .load(load),
      .blank_mask(mask8), .brightness(brightness), .segs(segs8),
      .scan_seg(scan_seg8), .scan_dig(scan_dig8), .shown(shown8)
   );

   hex_display_ctrl #(.DIGITS(3), .ACTIVE_LOW(1'b0), .SCAN_DIV(4), .PWM_BITS(4)) u_dut3 (
      .clk(clk), .reset_in(reset_in), .value(value3), .load(load),
      .blank_mask(mask3), .brightness(brightness), .segs(segs3),
      .scan_seg(scan_seg3), .scan_dig(scan_dig3), .shown(shown3)
   );

   hex_display_ctrl #(.DIGITS(1), .ACTIVE_LOW(1'b1), .SCAN_DIV(2), .PWM_BITS(4)) u_dut1 (
      .clk(clk), .reset_in(reset_in), .value(value1), .load(load),
      .blank_mask(mask1), .brightness(brightness), .segs(segs1),
      .scan_seg(scan_seg1), .scan_dig(scan_dig1), .shown(shown1)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      string       name;
      logic [31:0] value;
      logic [7:0]  mask;
      logic [55:0] exp;   // active-high patterns, digit7 .. digit0
   } vec_t;

   vec_t vecs[8];

   // Watchdog: the sequence is a few hundred cycles long.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [55:0] exp_pins;
      logic [47:0] pwm_bits;
      logic        prev_lit;
      logic        cur_lit;
      logic        found;
      logic [6:0]  pat3 [3];
      logic [2:0]  exp_dig3;

      vecs[0] = '{"lzb_top",   32'h0123ABCF, 8'h00,
`ifdef HEXDISP_LZB_EN
                  {7'h00, 7'h06, 7'h5B, 7'h4F, 7'h77, 7'h7C, 7'h39, 7'h71}};
`else
                  {7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h77, 7'h7C, 7'h39, 7'h71}};
`endif
      vecs[1] = '{"hex_8_f",   32'h89ABCDEF, 8'h00,
                  {7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71}};
      vecs[2] = '{"dec_0_7",   32'h01234567, 8'h00,
`ifdef HEXDISP_LZB_EN
                  {7'h00, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07}};
`else
                  {7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07}};
`endif
      vecs[3] = '{"mask_low",  32'h76543210, 8'h0F,
                  {7'h07, 7'h7D, 7'h6D, 7'h66, 7'h00, 7'h00, 7'h00, 7'h00}};
      vecs[4] = '{"all_zero",  32'h00000000, 8'h00,
`ifdef HEXDISP_LZB_EN
                  {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h3F}};
`else
                  {8{7'h3F}}};
`endif
      vecs[5] = '{"zero_a0",   32'h000000A0, 8'h00,
`ifdef HEXDISP_LZB_EN
                  {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h77, 7'h3F}};
`else
                  {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h77, 7'h3F}};
`endif
      vecs[6] = '{"mask_alt",  32'hFFFFFFFF, 8'hAA,
                  {7'h00, 7'h71, 7'h00, 7'h71, 7'h00, 7'h71, 7'h00, 7'h71}};
      vecs[7] = '{"mask_top",  32'h00100000, 8'h80,
`ifdef HEXDISP_LZB_EN
                  {7'h00, 7'h00, 7'h06, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F}};
`else
                  {7'h00, 7'h3F, 7'h06, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F}};
`endif

      pat3[0] = 7'h4F;  // value3 = 5A3: digit0 = 3
      pat3[1] = 7'h77;  // digit1 = A
      pat3[2] = 7'h6D;  // digit2 = 5

      reset_in   = 1'b1;
      load       = 1'b0;
      brightness = 4'hF;
      value8 = '0; mask8 = '0;
      value3 = 12'h111; mask3 = '0;
      value1 = 4'h7; mask1 = '0;
      repeat (2) @(negedge clk);
      reset_in = 1'b0;

      // ---- No load yet: everything dark even at full brightness ----
      repeat (100) @(negedge clk);
      check("idle_segs8",     segs8,     64'hFF_FFFF_FFFF_FFFF);
      check("idle_scan_dig8", scan_dig8, 64'hFF);
      check("idle_scan_seg8", scan_seg8, 64'h7F);
      check("idle_shown8",    shown8,    64'h0);
      check("idle_segs3",     segs3,     64'h0);
      check("idle_scan_dig3", scan_dig3, 64'h0);

      // ---- Table-driven static font / mask / LZB vectors ----
      for (int i = 0; i < 8; i++) begin
         value8 = vecs[i].value;
         mask8  = vecs[i].mask;
         load   = 1'b1;
         @(negedge clk);
         load     = 1'b0;
         exp_pins = ~vecs[i].exp;
         check({vecs[i].name, "_segs"},  segs8,  {8'h00, exp_pins});
         check({vecs[i].name, "_shown"}, shown8, 64'h1);
      end

      // ---- value changes without load are ignored ----
      value8 = 32'hDEADBEEF;
      mask8  = 8'h00;
      repeat (3) @(negedge clk);
      exp_pins = ~vecs[7].exp;
      check("hold_no_load", segs8, {8'h00, exp_pins});

      // ---- Back-to-back loads: each visible one cycle later ----
      value8 = 32'h11111111;
      load   = 1'b1;
      @(negedge clk);
      value8 = 32'h22222222;
      check("b2b_first",  segs8, {8'h00, ~{8{7'h06}}});
      @(negedge clk);
      load = 1'b0;
      check("b2b_second", segs8, {8'h00, ~{8{7'h5B}}});

      // ---- PWM: 4/16 duty, then 12/16 starting at the wrap ----
      value8 = 32'h88888888;
      load   = 1'b1;
      @(negedge clk);
      load       = 1'b0;
      brightness = 4'd4;
      repeat (40) @(negedge clk);
      // First lit cycle after a dark one marks counter value 0.
      found    = 1'b0;
      prev_lit = (segs8[6:0] != 7'h7F);
      for (int c = 0; c < 40 && !found; c++) begin
         @(negedge clk);
         cur_lit = (segs8[6:0] != 7'h7F);
         if (!prev_lit && cur_lit) found = 1'b1;
         prev_lit = cur_lit;
      end
      check("pwm_sync_found", found, 64'h1);
      pwm_bits    = '0;
      pwm_bits[0] = (segs8[6:0] != 7'h7F);
      for (int c = 1; c < 48; c++) begin
         @(negedge clk);
         pwm_bits[c] = (segs8[6:0] != 7'h7F);
         if (c == 5) brightness = 4'd12;  // mid-period change
      end
      check("pwm_duty4",        pwm_bits[15:0],  64'h000F);
      check("pwm_duty12_wrap",  pwm_bits[31:16], 64'h0FFF);
      check("pwm_duty12_again", pwm_bits[47:32], 64'h0FFF);

      brightness = 4'hF;
      repeat (40) @(negedge clk);

      // ---- Reset mid-slot with load asserted ----
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         if (scan_dig3 != 3'b000) found = 1'b1;
         else @(negedge clk);
      end
      check("mid_slot_found", found, 64'h1);
      reset_in = 1'b1;
      load     = 1'b1;
      value8   = 32'hFFFFFFFF;
      @(negedge clk);
      reset_in = 1'b0;
      load     = 1'b0;
      // cycle 0 after reset
      check("rst_segs8",     segs8,     64'hFF_FFFF_FFFF_FFFF);
      check("rst_shown8",    shown8,    64'h0);
      check("rst_scan_dig8", scan_dig8, 64'hFF);
      check("rst_scan_seg8", scan_seg8, 64'h7F);
      check("rst_segs3",     segs3,     64'h0);
      check("rst_shown3",    shown3,    64'h0);
      check("rst_scan_dig3", scan_dig3, 64'h0);
      check("rst_scan_dig1", scan_dig1, 64'h1);

      // load during cycle 0; brightness register is 0 until the wrap at 16
      value3 = 12'h5A3;
      value1 = 4'h7;
      load   = 1'b1;
      @(negedge clk);  // cycle 1
      load = 1'b0;
      check("post_rst_shown3", shown3, 64'h1);
      check("post_rst_dim3",   segs3,  64'h0);
      repeat (14) @(negedge clk);  // cycle 15
      check("pre_wrap_dark3",  segs3,  64'h0);
      @(negedge clk);              // cycle 16
      check("wrap_lit3",       segs3,  {43'h0, 7'h6D, 7'h77, 7'h4F});
      repeat (8) @(negedge clk);   // cycle 24: index 0, GAP

      // ---- Scan sequence over cycles 24..36 ----
      for (int k = 24; k <= 36; k++) begin
         exp_dig3 = (k % 4 == 0) ? 3'b000 : (3'b001 << ((k / 4) % 3));
         check($sformatf("scan3_dig_c%0d", k), scan_dig3, {61'h0, exp_dig3});
         check($sformatf("scan3_seg_c%0d", k), scan_seg3, {57'h0, pat3[(k / 4) % 3]});
         check($sformatf("scan1_dig_c%0d", k), scan_dig1, (k % 2 == 0) ? 64'h1 : 64'h0);
         check($sformatf("scan1_seg_c%0d", k), scan_seg1, 64'h78);
         if (k < 36) @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
